// File: rtl/lcf_pkg.sv
// Shared constants, default-size types and width helpers for the latency credit FIFO.
package lcf_pkg;

  localparam int LCF_DEFAULT_DEPTH   = 8;
  localparam int LCF_DEFAULT_LATENCY = 4;

  function automatic int lcf_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int lcf_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int LCF_PTR_W = lcf_ptr_w(LCF_DEFAULT_DEPTH);
  localparam int LCF_CNT_W = lcf_cnt_w(LCF_DEFAULT_DEPTH);

  typedef logic [LCF_PTR_W-1:0] ptr_t;
  typedef logic [LCF_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/lcf_storage.sv
// DEPTH x WIDTH buffer array: one synchronous write port, one asynchronous read port.
// The array is deliberately not reset; validity is tracked by the owner's count.
module lcf_storage
  import lcf_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = LCF_DEFAULT_DEPTH,
  localparam int AW = lcf_ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/latency_credit_fifo.sv
// Credit-issuing receive buffer at the output of a fixed-latency pipeline; first-word fall-through output.
// Define LCF_BYPASS_EN to forward pipe_data straight to out_data when the buffer is empty.
module latency_credit_fifo
  import lcf_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int LATENCY = LCF_DEFAULT_LATENCY,
  parameter int DEPTH   = LCF_DEFAULT_DEPTH,
  localparam int PW = lcf_ptr_w(DEPTH),
  localparam int CW = lcf_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic             pipe_valid,
  input  logic [WIDTH-1:0] pipe_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             err
);

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    inflight;
  logic [CW:0]      used;
  logic [WIDTH-1:0] mem_rd, last_data;
  logic             full, empty, fire, pop, wr_en, byp_take, inf_dec;
  logic [LATENCY-1:0] fire_sr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Credits are DEPTH minus everything stored or already launched.
  assign used        = {1'b0, count} + {1'b0, inflight};
  assign issue_ready = (used < (CW+1)'(DEPTH));
  assign fire        = issue_valid && issue_ready;

`ifdef LCF_BYPASS_EN
  assign byp_take  = empty && pipe_valid && out_ready;
  assign out_valid = !empty || pipe_valid;
  assign out_data  = !empty ? mem_rd : (pipe_valid ? pipe_data : last_data);
`else
  assign byp_take  = 1'b0;
  assign out_valid = !empty;
  assign out_data  = !empty ? mem_rd : last_data;
`endif

  assign pop     = !empty && out_ready;
  assign wr_en   = pipe_valid && !byp_take && (!full || pop);
  assign inf_dec = pipe_valid && (inflight != '0);

  lcf_storage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_storage (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (pipe_data),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      inflight  <= '0;
      last_data <= '0;
      err       <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr    <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
        last_data <= mem_rd;
      end
      if (byp_take) last_data <= pipe_data;

      if (wr_en && !pop)      count <= count + CW'(1);
      else if (!wr_en && pop) count <= count - CW'(1);

      if (fire && !inf_dec)      inflight <= inflight + CW'(1);
      else if (!fire && inf_dec) inflight <= inflight - CW'(1);

      // Unsolicited arrival, or arrival with no room and nothing leaving.
      if (pipe_valid && ((inflight == '0) || (full && !pop))) err <= 1'b1;
    end
  end

  // Launch history used only to confirm the pipeline honours LATENCY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fire_sr <= '0;
    else     fire_sr <= LATENCY'({fire_sr, fire});
  end

  always_ff @(posedge clk) begin
    if (!rst && fire_sr[LATENCY-1]) assert (pipe_valid);
  end

endmodule

// File: tb/tb_latency_credit_fifo.sv
// Directed plus randomized bench for latency_credit_fifo against a queue-based model.
module tb_latency_credit_fifo;
  import lcf_pkg::*;

  localparam int W  = 64;
  localparam int D  = 8;
  localparam int L  = 4;
  localparam int CW = $clog2(D) + 1;
`ifdef LCF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0, rst = 1'b1;
  logic          issue_valid = 1'b0, issue_ready;
  logic          pipe_valid = 1'b0;
  logic [W-1:0]  pipe_data = '0;
  logic          out_valid, out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [CW-1:0] count;
  logic          err;

  always #5 clk = ~clk;

  latency_credit_fifo #(.WIDTH(W), .LATENCY(L), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .pipe_valid(pipe_valid), .pipe_data(pipe_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .err(err)
  );

  int passed = 0, total = 0;

  // Reference state: stored items in order, outstanding launches, sticky error, last delivered word.
  logic [W-1:0] mq[$];
  int           m_inflight;
  bit           m_err;
  logic [W-1:0] m_last;

  // Ideal pipeline: slot k is what arrives k+1 edges from now.
  bit           dl_v[L];
  logic [W-1:0] dl_d[L];
  bit           uns_v = 1'b0;
  logic [W-1:0] uns_d = '0;
  logic [W-1:0] data_seq = '0;
  int           fires;
  bit           ready_dropped;
  logic [W-1:0] popped[$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    bit           pv, fire, byp, exp_ov, exp_ir, stored_pop, leave;
    logic [W-1:0] pd, exp_od;
    int           sz;
    pv = dl_v[0] || uns_v;
    pd = dl_v[0] ? dl_d[0] : uns_d;
    pipe_valid = pv;
    pipe_data  = pd;
    #1;
    sz     = mq.size();
    byp    = BYP && (sz == 0) && pv;
    exp_ov = (sz != 0) || byp;
    exp_od = (sz != 0) ? mq[0] : (byp ? pd : m_last);
    exp_ir = (D - sz - m_inflight) > 0;
    check("issue_ready", W'(issue_ready), W'(exp_ir));
    check("out_valid",   W'(out_valid),   W'(exp_ov));
    check("out_data",    out_data,        exp_od);
    check("count",       W'(count),       W'(sz));
    check("err",         W'(err),         W'(m_err));
    if (!issue_ready) ready_dropped = 1'b1;
    fire       = issue_valid && exp_ir;
    leave      = exp_ov && out_ready;
    stored_pop = (sz != 0) && out_ready;
    if (leave) popped.push_back(exp_od);
    @(posedge clk);
    if (pv && m_inflight == 0) m_err = 1'b1;
    if (pv && m_inflight > 0) m_inflight--;
    if (fire) m_inflight++;
    if (leave) m_last = exp_od;
    if (stored_pop) void'(mq.pop_front());
    if (pv && !(byp && out_ready)) begin
      if (sz < D || stored_pop) mq.push_back(pd);
      else m_err = 1'b1;
    end
    for (int k = 0; k < L-1; k++) begin
      dl_v[k] = dl_v[k+1];
      dl_d[k] = dl_d[k+1];
    end
    dl_v[L-1] = fire;
    dl_d[L-1] = data_seq;
    if (fire) begin
      data_seq++;
      fires++;
    end
    uns_v = 1'b0;
    #1;
    pipe_valid = dl_v[0];
    pipe_data  = dl_d[0];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    issue_valid = 1'b0;
    out_ready = 1'b0;
    uns_v = 1'b0;
    for (int k = 0; k < L; k++) begin
      dl_v[k] = 1'b0;
      dl_d[k] = '0;
    end
    pipe_valid = 1'b0;
    pipe_data  = '0;
    mq.delete();
    m_inflight = 0;
    m_err = 1'b0;
    m_last = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset and idle
    do_reset();
    #1;
    check("rst_issue_ready", W'(issue_ready), W'(1));
    check("rst_out_valid",   W'(out_valid),   W'(0));
    check("rst_count",       W'(count),       W'(0));
    check("rst_err",         W'(err),         W'(0));
    check("rst_out_data",    out_data,        '0);
    repeat (3) tick();

    // Full-rate stream
    do_reset();
    popped.delete();
    data_seq = '0;
    fires = 0;
    ready_dropped = 1'b0;
    issue_valid = 1'b1;
    out_ready = 1'b1;
    repeat (100) tick();
    issue_valid = 1'b0;
    repeat (L + 3) tick();
    check("stream_fires",     W'(fires),         W'(100));
    check("stream_outputs",   W'(popped.size()), W'(100));
    check("stream_ready_drop", W'(ready_dropped), W'(0));
    check("stream_err",       W'(err),           W'(0));
    for (int i = 0; i < popped.size(); i++) check("stream_order", popped[i], W'(i));

    // Backpressure: credits run out at DEPTH
    do_reset();
    fires = 0;
    issue_valid = 1'b1;
    out_ready = 1'b0;
    repeat (16) tick();
    check("bp_fires",       W'(fires),       W'(D));
    check("bp_issue_ready", W'(issue_ready), W'(0));
    check("bp_count",       W'(count),       W'(D));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_ready_after_pop", W'(issue_ready), W'(1));
    check("bp_count_after_pop", W'(count),       W'(D-1));
    tick();
    issue_valid = 1'b0;
    out_ready = 1'b1;
    repeat (L + D + 2) tick();
    check("bp_drained", W'(count), W'(0));
    check("bp_err",     W'(err),   W'(0));

    // Unsolicited arrival is stored and flagged
    do_reset();
    uns_v = 1'b1;
    uns_d = 64'hDEAD;
    tick();
    check("uns_err",      W'(err),   W'(1));
    check("uns_count",    W'(count), W'(1));
    check("uns_out_data", out_data,  64'hDEAD);

    // Overflow drops the extra word
    for (int i = 1; i < D; i++) begin
      uns_v = 1'b1;
      uns_d = W'(i);
      tick();
    end
    check("ovf_full", W'(count), W'(D));
    uns_v = 1'b1;
    uns_d = 64'hBEEF;
    tick();
    check("ovf_err",      W'(err),   W'(1));
    check("ovf_count",    W'(count), W'(D));
    check("ovf_out_data", out_data,  64'hDEAD);
    popped.delete();
    out_ready = 1'b1;
    repeat (D + 2) tick();
    check("ovf_drain_n", W'(popped.size()), W'(D));
    check("ovf_drain_0", popped[0], 64'hDEAD);
    for (int i = 1; i < popped.size(); i++) check("ovf_drain", popped[i], W'(i));
    check("ovf_hold_last", out_data, W'(D-1));

    // Arrival into an empty buffer with a ready consumer
    do_reset();
    out_ready = 1'b1;
    data_seq = 64'h55;
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    repeat (L - 1) tick();
    pipe_valid = dl_v[0];
    pipe_data  = dl_d[0];
    #1;
    check("byp_pipe_valid", W'(pipe_valid), W'(1));
    check("byp_out_valid",  W'(out_valid),  W'(BYP));
    check("byp_out_data",   out_data,       BYP ? 64'h55 : 64'h0);
    tick();
    check("byp_count_next",     W'(count),     W'(!BYP));
    check("byp_out_valid_next", W'(out_valid), W'(!BYP));
    tick();
    check("byp_count_final", W'(count),  W'(0));
    check("byp_last_data",   out_data,   64'h55);
    check("byp_err",         W'(err),    W'(0));

    // Randomized traffic with occasional unsolicited data and mid-run reset
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      issue_valid = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      if (!dl_v[0] && $urandom_range(0, 39) == 0) begin
        uns_v = 1'b1;
        uns_d = {$urandom, $urandom};
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
